// File: rtl/pla_eval_pkg.sv
// Shared types for the sequential PLA evaluator.
//   state_t    : scan FSM states
//   cube_t     : one cube (care mask, literal values, driven outputs), sized
//                to the widest legal configuration; narrower instances
//                zero-extend into it
//   cube_match : 1 when every cared-for literal equals the input bit
package pla_eval_pkg;

  localparam int unsigned MAX_IN  = 32;
  localparam int unsigned MAX_OUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef struct packed {
    logic [MAX_IN-1:0]  care;
    logic [MAX_IN-1:0]  val;
    logic [MAX_OUT-1:0] outs;
  } cube_t;

  // Zero care bits force their term to 1, so a zero-extended cube is unaffected
  // by the unused upper bits.
  function automatic logic cube_match(input logic [MAX_IN-1:0] care,
                                      input logic [MAX_IN-1:0] val,
                                      input logic [MAX_IN-1:0] vec);
    return &(~care | ~(vec ^ val));
  endfunction

endpackage

// File: rtl/pla_cube_store.sv
// Cube register file: NUM_CUBES entries of care/val/out.
//   clk, rst_n           : clock, async active-low reset (clears valid flags only)
//   we, wr_addr, wr_*    : synchronous write port
//   rd_addr              : asynchronous read address
//   rd_cube, rd_valid    : read data (zero-extended to cube_t) and entry-valid flag
module pla_cube_store
  import pla_eval_pkg::*;
#(
  parameter  int NUM_IN    = 10,
  parameter  int NUM_OUT   = 1,
  parameter  int NUM_CUBES = 64,
  localparam int AW        = $clog2(NUM_CUBES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [NUM_IN-1:0]  wr_care,
  input  logic [NUM_IN-1:0]  wr_val,
  input  logic [NUM_OUT-1:0] wr_out,
  input  logic [AW-1:0]      rd_addr,
  output cube_t              rd_cube,
  output logic               rd_valid
);

  logic [NUM_IN-1:0]  care_mem [NUM_CUBES];
  logic [NUM_IN-1:0]  val_mem  [NUM_CUBES];
  logic [NUM_OUT-1:0] out_mem  [NUM_CUBES];
  logic [NUM_CUBES-1:0] valid;

  always_ff @(posedge clk) begin
    if (we) begin
      care_mem[wr_addr] <= wr_care;
      val_mem[wr_addr]  <= wr_val;
      out_mem[wr_addr]  <= wr_out;
    end
  end

  // An entry with no driven outputs can never contribute, so it is stored as invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_addr] <= |wr_out;
    end
  end

  always_comb begin
    rd_cube      = '0;
    rd_cube.care = MAX_IN'(care_mem[rd_addr]);
    rd_cube.val  = MAX_IN'(val_mem[rd_addr]);
    rd_cube.outs = MAX_OUT'(out_mem[rd_addr]);
    rd_valid     = valid[rd_addr];
  end

endmodule

// File: rtl/pla_seq_eval.sv
// Sequential sum-of-products evaluator: scans one programmable cube per cycle,
// ORs the outputs of matching cubes, optionally complements per output.
//   prog_we/prog_addr/prog_care/prog_val/prog_out : cube write, taken in IDLE
//   prog_ready                                    : high in IDLE
//   in_valid/in_ready/in_data/cfg_invert          : input vector handshake
//   out_valid/out_ready/out_data                  : result handshake
module pla_seq_eval
  import pla_eval_pkg::*;
#(
  parameter  int NUM_IN    = 10,
  parameter  int NUM_OUT   = 1,
  parameter  int NUM_CUBES = 64,
  localparam int AW        = $clog2(NUM_CUBES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  output logic               prog_ready,
  input  logic [AW-1:0]      prog_addr,
  input  logic [NUM_IN-1:0]  prog_care,
  input  logic [NUM_IN-1:0]  prog_val,
  input  logic [NUM_OUT-1:0] prog_out,
  input  logic [NUM_OUT-1:0] cfg_invert,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_data
);

  localparam logic [AW-1:0]      LAST     = AW'(NUM_CUBES - 1);
  localparam logic [MAX_OUT-1:0] OUT_MASK = {MAX_OUT{1'b1}} >> (MAX_OUT - NUM_OUT);

  state_t             state;
  logic [AW-1:0]      idx;
  logic [NUM_OUT-1:0] acc;
  logic [NUM_IN-1:0]  vec;
  logic [NUM_OUT-1:0] inv;

  cube_t              cube;
  logic               cube_valid;
  logic               hit;
  logic [MAX_OUT-1:0] nxt_wide;
  logic [NUM_OUT-1:0] nxt;
  logic               full;

  assign in_ready   = (state == IDLE);
  assign prog_ready = (state == IDLE);

  pla_cube_store #(
    .NUM_IN    (NUM_IN),
    .NUM_OUT   (NUM_OUT),
    .NUM_CUBES (NUM_CUBES)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (prog_we && (state == IDLE)),
    .wr_addr  (prog_addr),
    .wr_care  (prog_care),
    .wr_val   (prog_val),
    .wr_out   (prog_out),
    .rd_addr  (idx),
    .rd_cube  (cube),
    .rd_valid (cube_valid)
  );

  // Accumulate at full cube width; bits above NUM_OUT are masked to 1 so the
  // all-ones early-exit test only looks at real outputs.
  always_comb begin
    hit      = cube_valid && cube_match(cube.care, cube.val, MAX_IN'(vec));
    nxt_wide = MAX_OUT'(acc) | (hit ? cube.outs : '0);
    full     = &(nxt_wide | ~OUT_MASK);
    nxt      = nxt_wide[NUM_OUT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      vec       <= '0;
      inv       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec   <= in_data;
            inv   <= cfg_invert;
            acc   <= '0;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          acc <= nxt;
          if (idx == LAST || full) begin
            out_valid <= 1'b1;
            out_data  <= nxt ^ inv;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
module tb_pla_seq_eval;

  localparam int NI = 10;
  localparam int NO = 2;
  localparam int NC = 64;
  localparam int AWT = $clog2(NC);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           prog_we = 1'b0;
  logic           prog_ready;
  logic [AWT-1:0] prog_addr = '0;
  logic [NI-1:0]  prog_care = '0;
  logic [NI-1:0]  prog_val = '0;
  logic [NO-1:0]  prog_out = '0;
  logic [NO-1:0]  cfg_invert = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [NI-1:0]  in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [NO-1:0]  out_data;

  pla_seq_eval #(
    .NUM_IN    (NI),
    .NUM_OUT   (NO),
    .NUM_CUBES (NC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_care  (prog_care),
    .prog_val   (prog_val),
    .prog_out   (prog_out),
    .cfg_invert (cfg_invert),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ecount = 0;
  bit hold = 1'b0;
  bit seen = 1'b0;

  always @(posedge clk) ecount++;

  always @(posedge clk) begin
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [NO-1:0] data;
    int            lat;
    int            t0;
  } exp_t;

  exp_t sb[$];

  // Reference cover: a cube with out==0 is absent.
  logic [NI-1:0] m_care [NC];
  logic [NI-1:0] m_val  [NC];
  logic [NO-1:0] m_out  [NC];

  function automatic void model_clear();
    for (int k = 0; k < NC; k++) m_out[k] = '0;
  endfunction

  function automatic exp_t model_eval(logic [NI-1:0] v, logic [NO-1:0] inv);
    exp_t e;
    logic [NO-1:0] acc;
    acc   = '0;
    e.lat = NC + 1;
    e.t0  = 0;
    for (int k = 0; k < NC; k++) begin
      if (m_out[k] != '0 && ((v ^ m_val[k]) & m_care[k]) == '0) acc |= m_out[k];
      if (acc == '1 && e.lat == NC + 1) e.lat = k + 2;
    end
    e.data = acc ^ inv;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency when out_valid first appears, data on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(ecount - sb[0].t0 + 1), 32'(sb[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          check("out_data", 32'(out_data), 32'(sb[0].data));
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic prog(logic [AWT-1:0] a, logic [NI-1:0] c, logic [NI-1:0] v, logic [NO-1:0] o);
    @(negedge clk);
    prog_addr = a; prog_care = c; prog_val = v; prog_out = o; prog_we = 1'b1;
    m_care[a] = c; m_val[a] = v; m_out[a] = o;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic apply(logic [NI-1:0] v, logic [NO-1:0] inv, bit do_wr,
                       logic [AWT-1:0] a, logic [NI-1:0] c, logic [NI-1:0] pv, logic [NO-1:0] o);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_data = v; cfg_invert = inv; in_valid = 1'b1;
    if (do_wr) begin
      prog_addr = a; prog_care = c; prog_val = pv; prog_out = o; prog_we = 1'b1;
      m_care[a] = c; m_val[a] = pv; m_out[a] = o;
    end
    e = model_eval(v, inv);
    @(posedge clk);
    #1;
    e.t0 = ecount;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    prog_we  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin @(posedge clk); t++; end
    if (sb.size() != 0) begin
      check("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(logic [NI-1:0] v, logic [NO-1:0] inv);
    apply(v, inv, 1'b0, '0, '0, '0, '0);
    wait_drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [NI-1:0] rv;
    model_clear();
    for (int k = 0; k < NC; k++) begin m_care[k] = '0; m_val[k] = '0; end

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_prog_ready", 32'(prog_ready), 32'd1);
    rst_n = 1'b1;

    // Empty table: full scan, result is the inversion mask.
    run(10'h000, 2'b00);
    run(10'h000, 2'b11);

    // Fully specified cube at index 5: early exit there.
    prog(6'd5, 10'h3FF, 10'h2A5, 2'b11);
    run(10'h2A5, 2'b00);
    run(10'h2A4, 2'b00);

    // Two partial cubes that together cover both outputs.
    prog(6'd0, 10'h000, 10'h000, 2'b01);
    prog(6'd3, 10'h3FF, 10'h155, 2'b10);
    run(10'h155, 2'b00);
    run(10'h155, 2'b10);

    // Backpressure: result held, programming ignored.
    @(negedge clk);
    hold = 1'b1;
    apply(10'h2A5, 2'b00, 1'b0, '0, '0, '0, '0);
    t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      prog_we = (c == 5);
      prog_addr = 6'd5; prog_care = 10'h3FF; prog_val = 10'h000; prog_out = 2'b00;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'd3);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    prog_we = 1'b0;
    hold = 1'b0;
    wait_drain();
    run(10'h2A5, 2'b00);

    // Write and accept in the same cycle: the new cube is visible.
    apply(10'h0F0, 2'b00, 1'b1, 6'd1, 10'h3FF, 10'h0F0, 2'b10);
    wait_drain();

    // Reset in the middle of a scan.
    prog(6'd40, 10'h3FF, 10'h333, 2'b11);
    @(negedge clk);
    in_data = 10'h333; cfg_invert = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid2", 32'(out_valid), 32'd0);
    run(10'h333, 2'b00);

    // Randomized covers against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        for (int p = 0; p < 12; p++) begin
          prog(AWT'($urandom_range(0, NC - 1)), NI'($urandom & $urandom),
               NI'($urandom), NO'($urandom_range(0, 3)));
        end
      end
      rv = NI'($urandom);
      run(rv, NO'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pla_seq_eval.md
Name: pla_seq_eval

Overview:
- Sequential, reprogrammable sum-of-products evaluator for PLA-style benchmark functions (ex1010 class). Generalises the fixed 10-input/1-output combinational netlists to NUM_IN inputs, NUM_OUT outputs and NUM_CUBES programmable cubes.
- Cubes are scanned one per cycle. Supports ON-set or OFF-set (inverted-output) mode per output, and early termination.
- Sits beside the synthesised netlists as a golden/reference evaluator for equivalence sweeps.

Parameters:
- NUM_IN, 10, number of function inputs (1..32)
- NUM_OUT, 1, number of function outputs (1..16)
- NUM_CUBES, 64, cube storage depth (power of two, 2..1024)
- AW, $clog2(NUM_CUBES), cube address width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  cube write strobe, honoured only when prog_ready=1
- prog_ready  out  1  high in IDLE
- prog_addr  in  AW  cube index
- prog_care  in  NUM_IN  1 = literal present
- prog_val  in  NUM_IN  literal polarity where care=1
- prog_out  in  NUM_OUT  outputs this cube drives; all-zero invalidates the entry
- cfg_invert  in  NUM_OUT  1 = output is OFF-set cover (complement the result); sampled at input accept
- in_valid  in  1  input vector valid
- in_ready  out  1  high in IDLE
- in_data  in  NUM_IN  input minterm
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_data  out  NUM_OUT  function value

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all cube prog_out fields cleared (every entry invalid).
  - out_valid=0, out_data=0, prog_ready=1, in_ready=1.
  - Care/val storage need not be cleared.
- Clearing is via a per-entry valid bit derived from prog_out != 0. Reset clears the NUM_CUBES valid flops only.
- Cube match: AND over i of (~care[i] | (in_data[i] == val[i])). A cube with care all-zero matches every vector.
- FSM IDLE:
  - prog_we writes entry prog_addr at the clock edge.
  - in_valid & in_ready latches in_data and cfg_invert, clears acc[NUM_OUT], sets idx=0, moves to SCAN.
  - If prog_we and in_valid are both high in the same cycle, the write commits first and the latched vector sees the new cube.
- FSM SCAN:
  - Each cycle: if entry idx is valid and matches, acc |= prog_out[idx].
  - Go to DONE when idx == NUM_CUBES-1, or when (acc | contribution) is all-ones (early exit). Otherwise idx++.
  - in_ready=0 and prog_ready=0; prog_we is ignored, with no side effect.
- FSM DONE:
  - out_valid=1 and out_data = acc ^ inv_latched; both held stable until out_ready.
  - out_valid & out_ready returns to IDLE; out_valid drops the following cycle.
  - A new input can be accepted no earlier than the cycle after the handshake.
- Latency from accept to out_valid:
  - worst case NUM_CUBES+1 cycles;
  - best case 2 (cube 0 sets every output).
- idx is AW bits wide. No wrap occurs because termination is checked at NUM_CUBES-1.
- Empty table (all entries invalid): full scan, out_data = cfg_invert.
- Reset asserted mid-SCAN or mid-DONE: immediate return to IDLE, any pending result discarded, cube table invalidated.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the vector is not latched.
- No combinational path from in_* to out_*.

Decomposition:
- Package pla_eval_pkg holds:
  - state enum {IDLE, SCAN, DONE}
  - a cube struct type built from the care/val/out fields
  - a helper function cube_match(care, val, vec)
- One sub-module, pla_cube_store: NUM_CUBES x (2*NUM_IN+NUM_OUT) register file with a synchronous write port, an asynchronous read port and a reset-cleared valid vector.
- The FSM, accumulator and handshake stay in pla_seq_eval.

Test Plan:
- Reset, then in_data=10'h000, cfg_invert=0, table empty -> out_data=0 after 65 cycles. With cfg_invert=1 -> out_data=1.
- Program cube 5 with care=10'h3FF, val=10'h2A5, out=1; apply 10'h2A5 -> out_data=1 after 7 cycles (early exit at idx 5). Apply 10'h2A4 -> 0 after 65 cycles.
- NUM_OUT=2: cube 0 out=2'b01 (care=0), cube 3 out=2'b10 matching vector -> out_data=2'b11 with early exit at idx 3. With cfg_invert=2'b10 -> 2'b01.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0. Assert prog_we during this time -> entry unchanged on readback by evaluation.
- Reset pulse mid-SCAN at idx 30 -> out_valid stays 0, in_ready=1 one cycle after release, previously programmed cube no longer matches (result 0).
- Random regression: program ex1010-style covers into NUM_IN=10, NUM_CUBES=256 and compare 1024 exhaustive vectors against a software SOP model -> zero mismatches.
